// File: rtl/dataflow_fork_if.sv
// Valid/ready bundle for the eager fork:
// one producer stream in, NUM_OUT consumer streams out.
interface dataflow_fork_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_OUT = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;

  // Environment side: drives the producer, sinks the branches
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Fork side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dataflow_fork.sv
// Registered eager fork: one held token, copied to
// NUM_OUT branches, retired when every branch took it.
module dataflow_fork #(
  parameter int WIDTH   = 32,
  parameter int NUM_OUT = 2
) (
  input logic         clk,
  input logic         rst,
  dataflow_fork_if.slave bus
);

  if (NUM_OUT < 1) begin : g_bad_num_out
    $error("dataflow_fork: NUM_OUT must be >= 1");
  end

  logic               full_q, full_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [NUM_OUT-1:0] sent_q, sent_d;

  logic [NUM_OUT-1:0] fire_out;
  logic               all_done;
  logic               fire_in;

  assign bus.out_valid = {NUM_OUT{full_q}} & ~sent_q;
  assign bus.out_data  = {NUM_OUT{data_q}};

  assign fire_out = bus.out_valid & bus.out_ready;
  assign all_done = full_q & (&(sent_q | fire_out));

  // Refill in the same cycle the last branch drains
  assign bus.in_ready = ~full_q | all_done;
  assign fire_in      = bus.in_valid & bus.in_ready;

  // Next-state: retire/refill, first fill, or collect copies
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    sent_d = sent_q;
    unique case (1'b1)
      all_done: begin
        full_d = fire_in;
        sent_d = '0;
        if (fire_in) data_d = bus.in_data;
      end
      !full_q: begin
        if (fire_in) begin
          full_d = 1'b1;
          data_d = bus.in_data;
          sent_d = '0;
        end
      end
      default: begin
        sent_d = sent_q | fire_out;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      sent_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      sent_q <= sent_d;
    end
  end

endmodule

// File: tb/tb_dataflow_fork.sv
// Bench for dataflow_fork: per-branch expected-token
// queues, directed scenarios and random traffic.
module tb_dataflow_fork;
  localparam int W = 32;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dataflow_fork_if #(.WIDTH(W), .NUM_OUT(N)) bus ();

  dataflow_fork #(.WIDTH(W), .NUM_OUT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int accepted = 0;

  // Each branch owes the consumer these tokens, in order
  logic [W-1:0] exp_q [N][$];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare outputs with the token-queue model
  always @(negedge clk) begin : mon
    logic [N-1:0] ev;
    logic         er;
    if (rst) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      er = 1'b1;
      for (int i = 0; i < N; i++) begin
        ev[i] = exp_q[i].size() != 0;
        if (ev[i] && !bus.out_ready[i]) er = 1'b0;
      end
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      chk("in_ready", 64'(bus.in_ready), 64'(er));
      for (int i = 0; i < N; i++) begin
        if (ev[i]) begin
          chk($sformatf("out_data[%0d]", i),
              64'(bus.out_data[i*W +: W]),
              64'(exp_q[i][0]));
          if (bus.out_ready[i]) void'(exp_q[i].pop_front());
        end
      end
      if (bus.in_valid && er) begin
        accepted++;
        for (int i = 0; i < N; i++)
          exp_q[i].push_back(bus.in_data);
      end
    end
  end

  initial begin
    int cyc;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state and idle
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    repeat (3) tick();

    // Broadcast, then a bubble-free stream
    bus.out_ready = 2'b11;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEADBEEF;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bcast_data", 64'(bus.out_data),
        {32'hDEADBEEF, 32'hDEADBEEF});
    tick();
    bus.in_valid = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      bus.in_data = 32'(v);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();

    // Skewed consumers: branch 1 held off
    bus.out_ready = 2'b01;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA5A5A5A5;
    tick();
    bus.in_data = 32'h5A5A5A5A;
    repeat (3) tick();
    @(negedge clk);
    chk("skew_valid", 64'(bus.out_valid), 64'b10);
    chk("skew_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.out_ready = 2'b11;
    @(negedge clk);
    chk("skew_refill", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();

    // Reset with a token half delivered
    bus.out_ready = 2'b10;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h12345678;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 2'b11;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) tick();

    // Stall: nothing moves while both branches block
    bus.out_ready = 2'b00;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hCAFEF00D;
    tick();
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = $urandom;
      @(negedge clk);
      chk("stall_data", 64'(bus.out_data),
          {32'hCAFEF00D, 32'hCAFEF00D});
      chk("stall_valid", 64'(bus.out_valid), 64'b11);
      chk("stall_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 2'b11;
    repeat (2) tick();

    // Random traffic: 1000 tokens, random backpressure
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.out_ready = N'($urandom);
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 2'b11;
    repeat (3) tick();
    chk("rand_tokens", 64'(accepted >= 1000), 64'd1);
    @(negedge clk);
    chk("drain_empty",
        64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dataflow_fork.md
# dataflow_fork

Registered eager fork for the valid/ready dataflow fabric. It accepts one token on a single input stream, holds it in a one-entry register, and offers a copy to each of NUM_OUT consumer streams independently. Each consumer may take its copy in a different cycle. The held token retires only when every branch has taken its copy. This is the fan-out counterpart of the two-operand join used by the arithmetic units: one producer's result feeds several operators.

## Interface
Parameters:
- WIDTH, 32, token data width in bits.
- NUM_OUT, 2, number of output branches; must be ≥ 1, and elaboration fails otherwise.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers a token.
- in_ready  output  1  fork accepts the offered token this cycle.
- in_data  input  WIDTH  token payload.
- out_valid  output  NUM_OUT  bit i high: branch i has an untaken copy.
- out_ready  input  NUM_OUT  bit i high: consumer i accepts this cycle.
- out_data  output  NUM_OUT*WIDTH  slice i is bits [i*WIDTH +: WIDTH]; every slice equals the held token.

## Operation
- State:
  - full_q: 1 bit, buffer holds a token.
  - data_q: WIDTH bits, the held token.
  - sent_q: NUM_OUT bits, branch i has already taken the current token.
- out_valid[i] = full_q & ~sent_q[i].
- out_data slice i = data_q for every i, regardless of valid.
- fire_out[i] = out_valid[i] & out_ready[i].
- all_done = full_q & AND over i of (sent_q[i] | fire_out[i]).
- in_ready = ~full_q | all_done. The fork accepts a new token in the same cycle the last outstanding branch completes.
- fire_in = in_valid & in_ready.
- Next-state rules, in priority order:
  - rst: full_q=0, sent_q=0, data_q=0.
  - all_done & fire_in: data_q<=in_data, full_q stays 1, sent_q<=0.
  - all_done & ~fire_in: full_q<=0, sent_q<=0.
  - ~full_q & fire_in: data_q<=in_data, full_q<=1, sent_q<=0.
  - full_q & ~all_done: sent_q <= sent_q | fire_out. data_q and full_q hold.
  - otherwise: hold.
- Each token is delivered exactly once per branch, in arrival order. No branch ever sees a token twice or skips a token.
- in_data is ignored when fire_in is low.

## Timing
- Reset values: in_ready=1 (buffer empty), out_valid=all 0, out_data=all 0.
- Latency: a token accepted at edge k appears on out_valid/out_data in the cycle after edge k.
- Throughput: 1 token/cycle sustained when all out_ready are held high.
- Combinational paths:
  - out_valid and out_data are register-driven only; there is no path from any input.
  - in_ready depends combinationally on out_ready and the state. There is no combinational path from in_valid or in_data to any output.
- Boundary cases:
  - Slow branch: faster branches complete, their sent bits set, and their out_valid drops. in_ready stays low until the slowest branch fires.
  - Simultaneous completion: all branches firing in the same cycle as in_valid high gives back-to-back tokens with no bubble.
  - NUM_OUT=1 degenerates to a full-throughput single pipeline register.
  - A consumer raising out_ready while its out_valid is low has no effect.
  - rst asserted mid-token: the held token is discarded and never re-offered. in_ready=1 in the cycle after the reset edge.

## Test plan
- Reset, then idle: with rst held 2 cycles, check in_ready=1 and out_valid=00 afterward, and that out_valid stays 00 while in_valid=0.
- Broadcast, NUM_OUT=2: send 0xDEADBEEF with both out_ready=1. Both branches show 0xDEADBEEF one cycle later and both fire together. Streaming 0x1,0x2,0x3 continuously yields one token per cycle on both branches with no bubbles.
- Skewed consumers: send 0xA5A5A5A5 with out_ready=01 for 3 cycles, then 11.
  - Branch 0 fires once, then out_valid=10.
  - in_ready stays 0 until branch 1 fires.
  - Next token 0x5A5A5A5A is accepted in that same cycle.
- Order and exactly-once: random out_ready per branch, 1000 random tokens. The scoreboard checks each branch receives the identical sequence with no duplicates or drops.
- Reset mid-token: hold 0x12345678 with out_ready=10, so branch 1 has fired and branch 0 has not. Pulse rst. Then out_valid=00, in_ready=1, and 0x12345678 never reappears.
- Stall hold: with out_ready=00 for 10 cycles, out_data and out_valid stay stable and in_ready=0 while in_valid toggles with changing in_data.
